// File: rtl/md_pkg.sv
// Shared constants and types for the multiply/divide scheduler.
package md_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;

  // Encoding follows the low two func bits of the start instructions.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    md_kind_e          kind;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } md_op_t;

endpackage

// File: rtl/md_decode.sv
// Combinational decoder for the HI/LO instruction class.
module md_decode
  import md_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  output logic            is_start_o,
  output md_kind_e        kind_o,
  output logic            is_mthi_o,
  output logic            is_mtlo_o,
  output logic            is_mfhi_o,
  output logic            is_mflo_o
);

  logic       special;
  logic [5:0] func;
  logic       unused_fields;

  assign special       = (ir_i[31:26] == OP_SPECIAL);
  assign func          = ir_i[5:0];
  assign unused_fields = ^ir_i[25:6];

  assign is_start_o = special && (func[5:2] == FUNC_MULT[5:2]);
  assign kind_o     = md_kind_e'(func[1:0]);
  assign is_mthi_o  = special && (func == FUNC_MTHI);
  assign is_mtlo_o  = special && (func == FUNC_MTLO);
  assign is_mfhi_o  = special && (func == FUNC_MFHI);
  assign is_mflo_o  = special && (func == FUNC_MFLO);

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler: launches ops from E, owns HI/LO, stalls D on HI/LO hazards.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] D_IR,
  input  logic [XLEN-1:0] E_IR,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            stall_md,
  output logic [XLEN-1:0] md_rd,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  logic      d_start, d_mthi, d_mtlo, d_mfhi, d_mflo;
  md_kind_e  d_kind;
  logic      e_start, e_mthi, e_mtlo, e_mfhi, e_mflo;
  md_kind_e  e_kind;
  logic      d_md;
  logic [1:0] unused_d_kind;

  md_decode u_dec_d (
    .ir_i       (D_IR),
    .is_start_o (d_start),
    .kind_o     (d_kind),
    .is_mthi_o  (d_mthi),
    .is_mtlo_o  (d_mtlo),
    .is_mfhi_o  (d_mfhi),
    .is_mflo_o  (d_mflo)
  );

  md_decode u_dec_e (
    .ir_i       (E_IR),
    .is_start_o (e_start),
    .kind_o     (e_kind),
    .is_mthi_o  (e_mthi),
    .is_mtlo_o  (e_mtlo),
    .is_mfhi_o  (e_mfhi),
    .is_mflo_o  (e_mflo)
  );

  assign unused_d_kind = d_kind;
  assign d_md = d_start | d_mthi | d_mtlo | d_mfhi | d_mflo;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_t           op_q, op_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;

  // Behavioural arithmetic on the latched operands; the counter models latency.
  logic signed [2*XLEN-1:0] ext_a, ext_b;
  logic [2*XLEN-1:0]        prod_s, prod_u;
  logic signed [XLEN-1:0]   sa, sb;
  logic [XLEN-1:0]          quo_s, rem_s, quo_u, rem_u;
  logic                     div_zero;

  assign ext_a    = {{XLEN{op_q.a[XLEN-1]}}, op_q.a};
  assign ext_b    = {{XLEN{op_q.b[XLEN-1]}}, op_q.b};
  assign prod_s   = ext_a * ext_b;
  assign prod_u   = {{XLEN{1'b0}}, op_q.a} * {{XLEN{1'b0}}, op_q.b};
  assign sa       = op_q.a;
  assign sb       = op_q.b;
  assign div_zero = (op_q.b == '0);

  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (!div_zero) begin
      quo_s = sa / sb;
      rem_s = sa % sb;
      quo_u = op_q.a / op_q.b;
      rem_u = op_q.a % op_q.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Start/move ops are honoured only while idle; a busy period ends on cnt==1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (e_start) begin
          op_d.kind = e_kind;
          op_d.a    = A;
          op_d.b    = B;
          cnt_d     = (e_kind inside {MD_DIV, MD_DIVU}) ? DIV_CNT : MULT_CNT;
          state_d   = ST_BUSY;
        end else if (e_mthi) begin
          hi_d = A;
        end else if (e_mtlo) begin
          lo_d = A;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          unique case (op_q.kind)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV: begin
              if (!div_zero) begin
                hi_d = rem_s;
                lo_d = quo_s;
              end
            end
            MD_DIVU: begin
              if (!div_zero) begin
                hi_d = rem_u;
                lo_d = quo_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_BUSY);
  assign stall_md = d_md & (busy | e_start);
  assign md_rd    = e_mfhi ? hi_q : (e_mflo ? lo_q : '0);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched against a cycle-timestamp reference model.
module tb_md_sched;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_ir = '0, e_ir = '0, a = '0, b = '0;
  logic        busy, stall_md;
  logic [31:0] md_rd, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_sched #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_IR     (d_ir),
    .E_IR     (e_ir),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .stall_md (stall_md),
    .md_rd    (md_rd),
    .HI       (hi),
    .LO       (lo)
  );

  always #5 clk = ~clk;

  // Reference model: an op launched at cycle m_t is busy for cycles m_t+1 .. m_t+m_lat.
  int          cyc = 0;
  int          m_t = -1000;
  int          m_lat = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  function automatic logic [5:0] fn(input logic [31:0] ir);
    return (ir[31:26] == 6'b0) ? ir[5:0] : 6'b111111;
  endfunction

  function automatic logic is_start(input logic [31:0] ir);
    return fn(ir) inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_md(input logic [31:0] ir);
    return fn(ir) inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO};
  endfunction

  function automatic logic m_busy();
    return (cyc > m_t) && (cyc <= m_t + m_lat);
  endfunction

  function automatic logic m_stall();
    return is_md(d_ir) && (m_busy() || is_start(e_ir));
  endfunction

  function automatic logic [31:0] m_rd();
    if (fn(e_ir) == F_MFHI) return m_hi;
    if (fn(e_ir) == F_MFLO) return m_lo;
    return 32'h0;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] f);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'b000000, mid, f};
  endfunction

  function automatic logic [31:0] mk_op(input logic [5:0] op);
    logic [25:0] rest;
    rest = 26'($urandom);
    return {op, rest};
  endfunction

  task automatic model_reset();
    m_t = -1000; m_lat = 0; m_valid = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic model_launch();
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    m_t = cyc;
    m_valid = 1'b1;
    case (fn(e_ir))
      F_MULT:  begin m_lat = MLAT; p = 64'(sa * sb); {m_rhi, m_rlo} = p; end
      F_MULTU: begin m_lat = MLAT; p = 64'(ua * ub); {m_rhi, m_rlo} = p; end
      F_DIV: begin
        m_lat = DLAT;
        if (b == 0) m_valid = 1'b0;
        else begin q = 64'(sa / sb); r = 64'(sa % sb); m_rlo = q[31:0]; m_rhi = r[31:0]; end
      end
      default: begin
        m_lat = DLAT;
        if (b == 0) m_valid = 1'b0;
        else begin q = 64'(ua / ub); r = 64'(ua % ub); m_rlo = q[31:0]; m_rhi = r[31:0]; end
      end
    endcase
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] aa, input logic [31:0] bb);
    d_ir = d; e_ir = e; a = aa; b = bb;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (m_busy()) begin
        if (cyc == m_t + m_lat && m_valid) begin m_hi = m_rhi; m_lo = m_rlo; end
      end else if (is_start(e_ir)) model_launch();
      else if (fn(e_ir) == F_MTHI) m_hi = a;
      else if (fn(e_ir) == F_MTLO) m_lo = a;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    drive(mk(F_MFLO), mk(F_MFHI), 32'h1234, 32'h5678);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    n_checks++;
    if (md_rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_md_rd got=%h required=00000000", md_rd);
    end
    n_checks++;
    if (stall_md !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall got=%b required=0", stall_md);
    end
    rst_n = 1'b1;
    model_reset();
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL post_reset busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic run_mul(input logic [5:0] f, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string tag);
    int nb;
    nb = 0;
    drive(32'h0, mk(f), 32'hFFFFFFFE, 32'h3);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(32'h0, 32'h0, 32'($urandom), 32'($urandom));
      n_checks++;
      if (busy !== m_busy()) begin
        n_fail++; $display("FAIL %s_busy cyc=%0d got=%b required=%b", tag, cyc, busy, m_busy());
      end
      if (busy === 1'b1) nb++;
      tick();
    end
    n_checks++;
    if (nb != MLAT) begin
      n_fail++; $display("FAIL %s_busy_len got=%0d required=%0d", tag, nb, MLAT);
    end
    drive(32'h0, mk(F_MFHI), 32'h0, 32'h0);
    n_checks++;
    if (md_rd !== exp_hi) begin
      n_fail++; $display("FAIL %s_mfhi got=%h required=%h", tag, md_rd, exp_hi);
    end
    tick();
    drive(32'h0, mk(F_MFLO), 32'h0, 32'h0);
    n_checks++;
    if (md_rd !== exp_lo || lo !== exp_lo) begin
      n_fail++; $display("FAIL %s_mflo md_rd=%h LO=%h required=%h", tag, md_rd, lo, exp_lo);
    end
    tick();
  endtask

  task automatic test_mult();
    run_mul(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
  endtask

  task automatic test_multu();
    run_mul(F_MULTU, 32'h00000002, 32'hFFFFFFFA, "multu");
  endtask

  task automatic test_div_stall();
    int ns;
    ns = 0;
    drive(mk(F_MFLO), mk(F_DIV), 32'hFFFFFFF9, 32'h2);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) drive(mk(F_MFLO), 32'h0, 32'($urandom), 32'($urandom));
      n_checks++;
      if (stall_md !== m_stall()) begin
        n_fail++; $display("FAIL div_stall cyc=%0d got=%b required=%b", cyc, stall_md, m_stall());
      end
      if (stall_md !== 1'b1) break;
      ns++;
      tick();
    end
    n_checks++;
    if (ns != DLAT + 1) begin
      n_fail++; $display("FAIL div_stall_len got=%0d required=%0d", ns, DLAT + 1);
    end
    tick();
    drive(32'h0, mk(F_MFLO), 32'h0, 32'h0);
    n_checks++;
    if (md_rd !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_lo got=%h required=fffffffd", md_rd);
    end
    tick();
    drive(32'h0, mk(F_MFHI), 32'h0, 32'h0);
    n_checks++;
    if (md_rd !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL div_hi got=%h required=ffffffff", md_rd);
    end
    tick();
  endtask

  task automatic test_divzero();
    int nb;
    nb = 0;
    drive(32'h0, mk(F_MTHI), 32'h11, 32'h0); tick();
    drive(32'h0, mk(F_MTLO), 32'h22, 32'h0); tick();
    drive(32'h0, mk(F_DIVU), 32'd100, 32'h0); tick();
    for (int k = 0; k < 14; k++) begin
      drive(32'h0, 32'h0, 32'($urandom), 32'($urandom));
      if (busy === 1'b1) nb++;
      tick();
    end
    n_checks++;
    if (nb != DLAT) begin
      n_fail++; $display("FAIL divzero_busy_len got=%0d required=%0d", nb, DLAT);
    end
    n_checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_fail++; $display("FAIL divzero_keep hi=%h lo=%h required 00000011/00000022", hi, lo);
    end
  endtask

  task automatic test_independent();
    logic [31:0] indep [3];
    int ns;
    indep[0] = mk(6'b100001);
    indep[1] = mk_op(6'b001101);
    indep[2] = mk_op(6'b100011);
    ns = 0;
    drive(32'h0, mk(F_MULT), 32'($urandom), 32'($urandom)); tick();
    for (int k = 0; k < 3; k++) begin
      drive(indep[k], (k > 0) ? indep[k-1] : 32'h0, 32'($urandom), 32'($urandom));
      n_checks++;
      if (stall_md !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL indep_nostall k=%0d stall=%b busy=%b required 0/1", k, stall_md, busy);
      end
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(mk(F_MFLO), (k == 0) ? indep[2] : 32'h0, 32'h0, 32'h0);
      if (stall_md !== 1'b1) break;
      ns++;
      tick();
    end
    n_checks++;
    if (ns != MLAT - 3) begin
      n_fail++; $display("FAIL indep_rem_stall got=%0d required=%0d", ns, MLAT - 3);
    end
    tick();
    drive(32'h0, mk(F_MFLO), 32'h0, 32'h0);
    n_checks++;
    if (md_rd !== m_lo) begin
      n_fail++; $display("FAIL indep_mflo got=%h required=%h", md_rd, m_lo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(32'h0, mk(F_MTHI), 32'hABCD, 32'h0); tick();
    drive(32'h0, mk(F_DIV), 32'd1000, 32'd7); tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
    drive(mk(F_MFLO), 32'h0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall_md !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async busy=%b hi=%h lo=%h stall=%b required 0/0/0/0",
                         busy, hi, lo, stall_md);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
        n_fail++; $display("FAIL midrst_nowrite k=%0d busy=%b hi=%h lo=%h", k, busy, hi, lo);
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_ir();
    case ($urandom_range(0, 11))
      0:  return mk(F_MULT);
      1:  return mk(F_MULTU);
      2:  return mk(F_DIV);
      3:  return mk(F_DIVU);
      4:  return mk(F_MFHI);
      5:  return mk(F_MFLO);
      6:  return mk(F_MTHI);
      7:  return mk(F_MTLO);
      8:  return mk(6'b100001);
      9:  return mk_op(6'b001101);
      10: return mk_op(6'b100011);
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] rb;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      drive(rnd_ir(), rnd_ir(), $urandom, rb);
      n_checks++;
      if (busy !== m_busy()) begin
        n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b required=%b", cyc, busy, m_busy());
      end
      n_checks++;
      if (stall_md !== m_stall()) begin
        n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b required=%b", cyc, stall_md, m_stall());
      end
      n_checks++;
      if (md_rd !== m_rd()) begin
        n_fail++; $display("FAIL rnd_md_rd cyc=%0d got=%h required=%h", cyc, md_rd, m_rd());
      end
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++; $display("FAIL rnd_hilo cyc=%0d hi=%h lo=%h required %h/%h", cyc, hi, lo, m_hi, m_lo);
      end
      tick();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mult();
    test_multu();
    test_div_stall();
    test_divzero();
    test_independent();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. It decodes the E-stage instruction, launches mult/multu/div/divu, and counts the fixed operation latency. It owns the HI/LO registers, serves mfhi/mflo reads to the E-stage result mux, and raises a stall request toward the D stage whenever an HI/LO-class instruction in D would collide with a pending operation.

## Interface
Parameters:
- MULT_LAT, 5: cycles busy for mult/multu.
- DIV_LAT, 10: cycles busy for div/divu.

Ports:
- clk  in  1  pipeline clock. One clock domain only.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- D_IR  in  32  instruction currently in D; used only for the stall decision.
- E_IR  in  32  instruction currently in E; decoded for start, mthi/mtlo and mfhi/mflo.
- A  in  32  forwarded rs value for the E instruction.
- B  in  32  forwarded rt value for the E instruction.
- busy  out  1  operation in flight.
- stall_md  out  1  freeze PC/F/D and insert a bubble into E.
- md_rd  out  32  HI when E_IR is mfhi, LO when E_IR is mflo, otherwise 0.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

## Operation
Decode uses SPECIAL (op 000000) with these func values:
- mult 011000, multu 011001, div 011010, divu 011011
- mfhi 010000, mflo 010010, mthi 010001, mtlo 010011
- md_D is true when D_IR is any of these eight instructions.

State machine IDLE/BUSY, with counter cnt[3:0]:
- IDLE, E_IR a start op: latch A, B and the op kind; cnt←LAT; go to BUSY.
- BUSY: cnt decrements every cycle. When cnt==1, write the result to HI/LO, go to IDLE, cnt←0.
- A start op in E while BUSY is impossible under correct stalling. It is ignored: no relaunch, and state is unchanged.

Results:
- mult: {HI,LO}←$signed(A)*$signed(B), full 64-bit product.
- multu: {HI,LO}←A*B, full 64-bit product.
- div: LO←signed quotient, HI←signed remainder, truncating toward zero. The remainder takes the sign of the dividend.
- divu: LO←unsigned quotient, HI←unsigned remainder.
- Divide by zero: full DIV_LAT busy period, and HI/LO are left unchanged.

Move and read instructions:
- mthi/mtlo in E while IDLE: HI←A or LO←A at the end of that cycle.
- mthi/mtlo in E while BUSY: ignored. This cannot happen under correct stalling.
- md_rd is combinational from the current HI/LO.

Stall rule:
- stall_md = md_D & (busy | start_E), where start_E is a start op decoded in E.

## Timing
- Reset: busy=0, stall_md=0, HI=0, LO=0, md_rd=0, state IDLE, cnt=0. Assertion mid-operation aborts the operation and does not write HI/LO.
- Start in E at cycle t: busy=1 during cycles t+1..t+LAT. The new HI/LO is visible from cycle t+LAT+1, when busy=0.
- mult at t followed by mflo in D at t: stall_md=1 for cycles t..t+LAT. mflo enters E at t+LAT+1 and reads the new LO.
- mfhi in E at the cycle in which a result is written reads the old value. This case cannot occur under correct stalling.
- Non-md instructions in D never stall, including while busy.
- A start in E and an mthi in D in the same cycle: stall_md=1.
- Start, mthi and mtlo take effect only on rising clk edges.

## Structure
- Package md_pkg holds:
  - the func constants above, and OP_SPECIAL;
  - the md_kind_e typedef: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the default latencies.
- One sub-module, md_decode: a combinational IR→{is_start, kind, is_mthi, is_mtlo, is_mfhi, is_mflo} decoder. It is instantiated twice, once for D_IR and once for E_IR.
- Arithmetic uses behavioural operators on the latched operands; there is no iterative datapath.

## Test plan
- mult, A=0xFFFFFFFE, B=3, then mfhi/mflo: busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- div, A=-7, B=2, followed immediately by mflo in D: stall_md high 11 cycles (start cycle + 10 busy); LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=100, B=0: busy 10 cycles; HI/LO retain prior values (preloaded via mthi 0x11, mtlo 0x22).
- mult issued, followed by independent addu, ori, lw: no stall. A later mflo stalls only for the remaining busy cycles.
- rst_n pulsed low at cycle 3 of a div: busy=0, HI=LO=0 asynchronously; no later write occurs.
